// File: rtl/lda_ovo_seq.sv
// Sequential one-vs-one linear discriminant classifier: one MAC lane per class pair,
// one feature dimension per cycle, then a pairwise vote tally and argmax.
module lda_ovo_seq #(
  parameter int unsigned DIMS    = 6,
  parameter int unsigned CLASSES = 3,
  parameter int unsigned DW      = 8,
  parameter int unsigned NPAIRS  = CLASSES * (CLASSES - 1) / 2,
  parameter int unsigned ACC_W   = 2 * DW + $clog2(DIMS) + 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [DIMS-1:0][DW-1:0]               din_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [NPAIRS-1:0][DIMS-1:0][DW-1:0]   w_i,
  input  logic [NPAIRS-1:0][ACC_W-1:0]          c_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [CLASSES-1:0]                    dout_o,
  output logic [$clog2(CLASSES)-1:0]            class_o,
  output logic                                  tie_o
);

  localparam int unsigned IW = (DIMS > 1) ? $clog2(DIMS) : 1;
  localparam int unsigned CW = $clog2(CLASSES);
  localparam int unsigned VW = CW;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIMS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_VOTE,
    S_OUT
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;

  logic [DIMS-1:0][DW-1:0]    r_din;
  logic [IW-1:0]              r_idx;
  logic signed [ACC_W-1:0]    r_acc [NPAIRS];

  logic [CLASSES-1:0]         r_dout;
  logic [CW-1:0]              r_class;
  logic                       r_tie;

  logic [DW-1:0]              w_dsel;
  logic signed [2*DW-1:0]     w_dext;
  logic signed [2*DW-1:0]     w_wext [NPAIRS];
  logic signed [2*DW-1:0]     w_prod [NPAIRS];
  logic signed [ACC_W-1:0]    w_term [NPAIRS];

  logic [VW-1:0]              w_votes [CLASSES];
  logic [VW-1:0]              w_vmax;
  logic [CW-1:0]              w_best;
  logic                       w_tie;
  logic [CLASSES-1:0]         w_onehot;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid_i)           w_state_nxt = S_ACCUM;
      S_ACCUM: if (r_idx == LAST_IDX)    w_state_nxt = S_VOTE;
      S_VOTE:                            w_state_nxt = S_OUT;
      S_OUT:   if (out_ready_i)          w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_OUT);

  // ---------------------------------------------------------------------------
  // MAC lanes: operands sign-extended to the full product width first so the
  // low 2*DW bits of the multiply are the exact signed product.
  // ---------------------------------------------------------------------------
  assign w_dsel = r_din[r_idx];
  assign w_dext = {{DW{w_dsel[DW-1]}}, w_dsel};

  for (genvar gp = 0; gp < NPAIRS; gp++) begin : g_mac
    assign w_wext[gp] = {{DW{w_i[gp][r_idx][DW-1]}}, w_i[gp][r_idx]};
    assign w_prod[gp] = w_dext * w_wext[gp];
    assign w_term[gp] = {{(ACC_W-2*DW){w_prod[gp][2*DW-1]}}, w_prod[gp]};
  end

  // ---------------------------------------------------------------------------
  // Pairwise votes and argmax (lowest index wins on equal counts)
  // ---------------------------------------------------------------------------
  always_comb begin
    int unsigned p;
    int unsigned n_at_max;
    p = 0;
    for (int unsigned k = 0; k < CLASSES; k++) begin
      w_votes[k] = '0;
    end
    for (int unsigned a = 0; a < CLASSES; a++) begin
      for (int unsigned b = a + 1; b < CLASSES; b++) begin
        if (r_acc[p] > $signed(c_i[p])) begin
          w_votes[b] = w_votes[b] + VW'(1);
        end else begin
          w_votes[a] = w_votes[a] + VW'(1);
        end
        p = p + 1;
      end
    end

    w_vmax = w_votes[0];
    w_best = '0;
    for (int unsigned k = 1; k < CLASSES; k++) begin
      if (w_votes[k] > w_vmax) begin
        w_vmax = w_votes[k];
        w_best = CW'(k);
      end
    end

    n_at_max = 0;
    for (int unsigned k = 0; k < CLASSES; k++) begin
      if (w_votes[k] == w_vmax) begin
        n_at_max = n_at_max + 1;
      end
    end
    w_tie = (n_at_max > 1);

    w_onehot         = '0;
    w_onehot[w_best] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_din   <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
      r_class <= '0;
      r_tie   <= 1'b0;
      for (int unsigned p = 0; p < NPAIRS; p++) begin
        r_acc[p] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_din <= din_i;
            r_idx <= '0;
            for (int unsigned p = 0; p < NPAIRS; p++) begin
              r_acc[p] <= '0;
            end
          end
        end
        S_ACCUM: begin
          for (int unsigned p = 0; p < NPAIRS; p++) begin
            r_acc[p] <= r_acc[p] + w_term[p];
          end
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        end
        S_VOTE: begin
          r_dout  <= w_onehot;
          r_class <= w_best;
          r_tie   <= w_tie;
        end
        default: ;
      endcase
    end
  end

  assign dout_o  = r_dout;
  assign class_o = r_class;
  assign tie_o   = r_tie;

endmodule
